key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 185 ++++++++++++++++++
 tb/tb_key_debounce.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce
//   Debounces four active-low board keys, produces a debounced active-high
//   level, one-cycle press/release pulses and (optionally) a small event
//   FIFO describing the accepted edges in the order they were seen.
//
//   Build option: define KEY_EVENT_FIFO_EN to include the pend logic, the
//   event FIFO and the overflow flag. Without it those outputs are tied low
//   and evt_ready_i is ignored.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples to accept a change (2..2^24)
//   FIFO_DEPTH       event FIFO depth, power of two (2..16)
//
// Ports
//   clk50m_i       system clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   key_i[3:0]     raw keys, 0 = pressed
//   key_state_o    debounced level, 1 = pressed
//   key_press_o    one-cycle pulse on accepted press
//   key_release_o  one-cycle pulse on accepted release
//   evt_valid_o    FIFO head holds an event
//   evt_ready_i    consumer takes the head event
//   evt_key_o      head event key index
//   evt_press_o    head event type, 1 = press
//   ovf_o          sticky: at least one event was lost
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk50m_i,
  input  logic       rst_n_i,
  input  logic [3:0] key_i,
  output logic [3:0] key_state_o,
  output logic [3:0] key_press_o,
  output logic [3:0] key_release_o,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [1:0] evt_key_o,
  output logic       evt_press_o,
  output logic       ovf_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync_q1;
  logic [3:0]       sync_q2;
  logic [3:0]       sample;
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       toggle;

  // Keys idle high; synchronizer resets to "released" so that a key held
  // through reset is seen as a fresh press afterwards.
  assign sample = ~sync_q2;

  // toggle[k] is the cycle in which the level change is accepted; it also
  // feeds the pend logic so the event is recorded alongside the pulse.
  always_comb begin
    toggle = '0;
    for (int k = 0; k < 4; k++) begin
      toggle[k] = (sample[k] != key_state_o[k]) && (cnt_q[k] == CNT_MAX);
    end
  end

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q1       <= '1;
      sync_q2       <= '1;
      key_state_o   <= '0;
      key_press_o   <= '0;
      key_release_o <= '0;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync_q1       <= key_i;
      sync_q2       <= sync_q1;
      key_state_o   <= key_state_o ^ toggle;
      key_press_o   <= toggle & ~key_state_o;
      key_release_o <= toggle & key_state_o;
      for (int k = 0; k < 4; k++) begin
        if ((sample[k] == key_state_o[k]) || toggle[k]) begin
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_EVENT_FIFO_EN

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]    pend_q;
  logic [3:0]    ptype_q;
  logic          ovf_q;
  logic [1:0]    mem_key   [FIFO_DEPTH];
  logic          mem_press [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          sel_valid;
  logic [1:0]    sel_key;
  logic [3:0]    push_mask;

  // Lowest-index pending key wins; descending loop so the last hit is key 0.
  always_comb begin
    sel_valid = 1'b0;
    sel_key   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_valid = 1'b1;
        sel_key   = 2'(k);
      end
    end
  end

  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop    = evt_valid_o && evt_ready_i;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push   = sel_valid && (!fifo_full || do_pop);
  assign push_mask = do_push ? (4'b0001 << sel_key) : 4'b0000;

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q   <= '0;
      ptype_q  <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_key[i]   <= 2'd0;
        mem_press[i] <= 1'b0;
      end
    end else begin
      pend_q <= (pend_q & ~push_mask) | toggle;
      for (int k = 0; k < 4; k++) begin
        if (toggle[k]) begin
          ptype_q[k] <= ~key_state_o[k];
        end
      end
      // An older event is only lost if it is not leaving this very cycle.
      if (|(toggle & pend_q & ~push_mask)) begin
        ovf_q <= 1'b1;
      end
      if (do_push) begin
        mem_key[wr_ptr_q]   <= sel_key;
        mem_press[wr_ptr_q] <= ptype_q[sel_key];
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt_valid_o = (count_q != '0);
  assign evt_key_o   = evt_valid_o ? mem_key[rd_ptr_q] : 2'd0;
  assign evt_press_o = evt_valid_o ? mem_press[rd_ptr_q] : 1'b0;
  assign ovf_o       = ovf_q;

`else

  logic unused_evt_ready;

  assign unused_evt_ready = evt_ready_i;
  assign evt_valid_o      = 1'b0;
  assign evt_key_o        = 2'd0;
  assign evt_press_o      = 1'b0;
  assign ovf_o            = 1'b0;

`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with DEBOUNCE_CYCLES=8, FIFO_DEPTH=4.
//   Event-FIFO expectations follow KEY_EVENT_FIFO_EN; without it the event
//   outputs and ovf_o are expected to stay low.
module tb_key_debounce;

  logic       clk50m_i;
  logic       rst_n_i;
  logic [3:0] key_i;
  logic [3:0] key_state_o;
  logic [3:0] key_press_o;
  logic [3:0] key_release_o;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_key_o;
  logic       evt_press_o;
  logic       ovf_o;

  int tests = 0;
  int fails = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(8),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk50m_i     (clk50m_i),
    .rst_n_i      (rst_n_i),
    .key_i        (key_i),
    .key_state_o  (key_state_o),
    .key_press_o  (key_press_o),
    .key_release_o(key_release_o),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_key_o    (evt_key_o),
    .evt_press_o  (evt_press_o),
    .ovf_o        (ovf_o)
  );

  initial clk50m_i = 1'b0;
  always #5 clk50m_i = ~clk50m_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic ev, input logic [1:0] ek, input logic ep);
`ifdef KEY_EVENT_FIFO_EN
    check({tag, "_valid"}, {7'd0, evt_valid_o}, {7'd0, ev});
    if (ev) begin
      check({tag, "_key"}, {6'd0, evt_key_o}, {6'd0, ek});
      check({tag, "_press"}, {7'd0, evt_press_o}, {7'd0, ep});
    end
`else
    check({tag, "_valid_tied"}, {7'd0, evt_valid_o}, 8'd0);
    check({tag, "_ovf_tied"}, {7'd0, ovf_o}, 8'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk50m_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  logic [3:0] seen_state;
  logic [3:0] seen_pulse;
  logic       seen_valid;
  logic       exp_ovf;

  initial begin
`ifdef KEY_EVENT_FIFO_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst_n_i     = 1'b0;
    key_i       = 4'hF;
    evt_ready_i = 1'b1;
    ticks(3);
    check("rst_state",   {4'd0, key_state_o},   8'd0);
    check("rst_press",   {4'd0, key_press_o},   8'd0);
    check("rst_release", {4'd0, key_release_o}, 8'd0);
    check("rst_valid",   {7'd0, evt_valid_o},   8'd0);
    check("rst_key",     {6'd0, evt_key_o},     8'd0);
    check("rst_evpress", {7'd0, evt_press_o},   8'd0);
    check("rst_ovf",     {7'd0, ovf_o},         8'd0);
    rst_n_i = 1'b1;
    ticks(3);

    // single press on key 0: accepted exactly 10 cycles after the change
    key_i = 4'hE;
    ticks(9);
    check("p0_state_early", {4'd0, key_state_o}, 8'h0);
    check("p0_press_early", {4'd0, key_press_o}, 8'h0);
    tick();
    check("p0_state", {4'd0, key_state_o}, 8'h1);
    check("p0_press", {4'd0, key_press_o}, 8'h1);
    tick();
    check("p0_press_done", {4'd0, key_press_o}, 8'h0);
    chk_evt("p0_evt", 1'b1, 2'd0, 1'b1);
    tick();
    chk_evt("p0_drain", 1'b0, 2'd0, 1'b0);

    key_i = 4'hF;
    ticks(9);
    check("r0_state_early", {4'd0, key_state_o}, 8'h1);
    tick();
    check("r0_state",   {4'd0, key_state_o},   8'h0);
    check("r0_release", {4'd0, key_release_o}, 8'h1);
    check("r0_press",   {4'd0, key_press_o},   8'h0);
    tick();
    chk_evt("r0_evt", 1'b1, 2'd0, 1'b0);
    tick();
    chk_evt("r0_drain", 1'b0, 2'd0, 1'b0);

    // 5-cycle glitch on key 2 must be ignored
    seen_state = '0;
    seen_pulse = '0;
    seen_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      key_i = (i < 5) ? 4'hB : 4'hF;
      tick();
      seen_state |= key_state_o;
      seen_pulse |= key_press_o | key_release_o;
      seen_valid |= evt_valid_o;
    end
    check("glitch_state", {4'd0, seen_state}, 8'h0);
    check("glitch_pulse", {4'd0, seen_pulse}, 8'h0);
    check("glitch_valid", {7'd0, seen_valid}, 8'h0);

    // all four keys at once: same-cycle pulses, events drain in key order
    key_i = 4'h0;
    ticks(9);
    check("all_state_early", {4'd0, key_state_o}, 8'h0);
    tick();
    check("all_state", {4'd0, key_state_o}, 8'hF);
    check("all_press", {4'd0, key_press_o}, 8'hF);
    tick();
    chk_evt("all_evt0", 1'b1, 2'd0, 1'b1);
    tick();
    chk_evt("all_evt1", 1'b1, 2'd1, 1'b1);
    tick();
    chk_evt("all_evt2", 1'b1, 2'd2, 1'b1);
    tick();
    chk_evt("all_evt3", 1'b1, 2'd3, 1'b1);
    tick();
    chk_evt("all_drain", 1'b0, 2'd0, 1'b0);

    key_i = 4'hF;
    ticks(10);
    check("allr_state",   {4'd0, key_state_o},   8'h0);
    check("allr_release", {4'd0, key_release_o}, 8'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_evt("allr_evt", 1'b1, 2'(k), 1'b0);
    end
    tick();
    chk_evt("allr_drain", 1'b0, 2'd0, 1'b0);
    check("allr_ovf", {7'd0, ovf_o}, 8'h0);

    // consumer stalled: six edges on key 1, FIFO fills, sixth edge overflows
    evt_ready_i = 1'b0;
    for (int t = 0; t < 72; t++) begin
      if ((t % 12) == 0) key_i = (((t / 12) % 2) == 0) ? 4'hD : 4'hF;
      tick();
      if (t + 1 == 48) chk_evt("ovf_head_full", 1'b1, 2'd1, 1'b1);
      if (t + 1 == 69) check("ovf_before", {7'd0, ovf_o}, 8'h0);
      if (t + 1 == 70) check("ovf_set", {7'd0, ovf_o}, {7'd0, exp_ovf});
    end
    chk_evt("ovf_head_hold", 1'b1, 2'd1, 1'b1);
    check("ovf_key1_state", {4'd0, key_state_o}, 8'h0);
    evt_ready_i = 1'b1;
    tick();
    chk_evt("ovf_drain1", 1'b1, 2'd1, 1'b0);
    tick();
    chk_evt("ovf_drain2", 1'b1, 2'd1, 1'b1);
    tick();
    chk_evt("ovf_drain3", 1'b1, 2'd1, 1'b0);
    tick();
    chk_evt("ovf_drain4", 1'b1, 2'd1, 1'b0);
    tick();
    chk_evt("ovf_drain_end", 1'b0, 2'd0, 1'b0);
    check("ovf_sticky", {7'd0, ovf_o}, {7'd0, exp_ovf});

    // reset with keys held and two events queued
    evt_ready_i = 1'b0;
    key_i = 4'hA;
    ticks(10);
    check("pre_rst_state", {4'd0, key_state_o}, 8'h5);
    check("pre_rst_press", {4'd0, key_press_o}, 8'h5);
    ticks(2);
    chk_evt("pre_rst_evt", 1'b1, 2'd0, 1'b1);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_state", {4'd0, key_state_o}, 8'h0);
    check("mid_rst_valid", {7'd0, evt_valid_o}, 8'h0);
    check("mid_rst_key",   {6'd0, evt_key_o},   8'h0);
    check("mid_rst_ovf",   {7'd0, ovf_o},       8'h0);
    tick();
    rst_n_i = 1'b1;
    ticks(9);
    check("post_rst_early", {4'd0, key_state_o}, 8'h0);
    tick();
    check("post_rst_state", {4'd0, key_state_o}, 8'h5);
    check("post_rst_press", {4'd0, key_press_o}, 8'h5);
    tick();
    chk_evt("post_rst_evt0", 1'b1, 2'd0, 1'b1);
    tick();
    chk_evt("post_rst_hold", 1'b1, 2'd0, 1'b1);
    evt_ready_i = 1'b1;
    tick();
    chk_evt("post_rst_evt2", 1'b1, 2'd2, 1'b1);
    tick();
    chk_evt("post_rst_drain", 1'b0, 2'd0, 1'b0);
    check("post_rst_ovf", {7'd0, ovf_o}, 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
